// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, register aliases and the opcode decoder shared by the ID stage.
package mips_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  typedef enum logic [1:0] {D_NONE, D_RD, D_RT, D_RA} dsel_e;
  typedef struct packed {
    logic use_rs;
    logic use_rt;
    logic zext;
    logic illegal;
    dsel_e dsel;
  } dec_t;
  typedef struct packed {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] shamt;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic [25:0] jtarget;
    logic [4:0] dest;
    logic we;
    logic illegal;
    logic [XLEN-1:0] pc;
  } ex_t;
  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d.use_rs = 1'b0;
    d.use_rt = 1'b0;
    d.illegal = 1'b0;
    d.dsel = D_NONE;
    d.zext = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    case (op)
      OP_RTYPE: begin d.use_rs = 1'b1; d.use_rt = 1'b1; d.dsel = D_RD; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
        d.use_rs = 1'b1;
        d.dsel = D_RT;
      end
      OP_LUI: d.dsel = D_RT;
      OP_SW, OP_BEQ, OP_BNE: begin d.use_rs = 1'b1; d.use_rt = 1'b1; end
      OP_J: d.dsel = D_NONE;
      OP_JAL: d.dsel = D_RA;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write bits; set on issue, cleared on writeback, set wins.
module id_scoreboard #(
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_i,
  input  logic [$clog2(NREG)-1:0] set_idx_i,
  input  logic                    clr_i,
  input  logic [$clog2(NREG)-1:0] clr_idx_i,
  input  logic [$clog2(NREG)-1:0] rs_idx_i,
  input  logic [$clog2(NREG)-1:0] rt_idx_i,
  input  logic [$clog2(NREG)-1:0] rd_idx_i,
  output logic                    rs_pend_o,
  output logic                    rt_pend_o,
  output logic                    rd_pend_o
);
  logic [NREG-1:0] pending_q, pending_d;
  always_comb begin
    pending_d = pending_q;
    if (clr_i && clr_idx_i != '0) pending_d[clr_idx_i] = 1'b0;
    if (set_i && set_idx_i != '0) pending_d[set_idx_i] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pending_q <= '0;
    else pending_q <= pending_d;
  assign rs_pend_o = pending_q[rs_idx_i];
  assign rt_pend_o = pending_q[rt_idx_i];
  assign rd_pend_o = pending_q[rd_idx_i];
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode with scoreboard stalls and a registered ID/EX output.
// ID_WB_BYPASS_EN forwards same-cycle writeback data and resolves RAW without an extra bubble.
module id_stage #(
  parameter int XLEN = mips_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs,
  output logic [4:0]      rf_rt,
  input  logic [XLEN-1:0] rf_out_a,
  input  logic [XLEN-1:0] rf_out_b,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [5:0]      ex_opcode,
  output logic [5:0]      ex_funct,
  output logic [4:0]      ex_shamt,
  output logic [XLEN-1:0] ex_rs_data,
  output logic [XLEN-1:0] ex_rt_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [25:0]     ex_jtarget,
  output logic [4:0]      ex_dest,
  output logic            ex_we,
  output logic            ex_illegal,
  output logic [XLEN-1:0] ex_pc
);
  import mips_pkg::*;
  dec_t dec;
  ex_t ex_q, ex_d;
  logic ex_valid_q, ex_valid_d;
  logic [4:0] rs, rt, rd, dest;
  logic we, rs_pend, rt_pend, rd_pend, byp_a, byp_b, stall, accept;
  logic [XLEN-1:0] imm, op_a, op_b;
  assign dec = decode(if_instr[31:26]);
  assign rs = if_instr[25:21];
  assign rt = if_instr[20:16];
  assign rd = if_instr[15:11];
  assign rf_rs = rs;
  assign rf_rt = rt;
  assign dest = dec.dsel == D_RD ? rd : dec.dsel == D_RT ? rt : dec.dsel == D_RA ? REG_RA : REG_ZERO;
  assign we = dest != REG_ZERO;
  assign imm = dec.zext ? {{(XLEN-16){1'b0}}, if_instr[15:0]} : {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
`ifdef ID_WB_BYPASS_EN
  assign byp_a = wb_valid && wb_rd == rs;
  assign byp_b = wb_valid && wb_rd == rt;
`else
  logic unused_wb;
  assign unused_wb = ^wb_data;
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif
  id_scoreboard #(.NREG(NREG)) u_sb (
    .clk(clk), .rst(rst),
    .set_i(accept && we), .set_idx_i(dest),
    .clr_i(wb_valid), .clr_idx_i(wb_rd),
    .rs_idx_i(rs), .rt_idx_i(rt), .rd_idx_i(dest),
    .rs_pend_o(rs_pend), .rt_pend_o(rt_pend), .rd_pend_o(rd_pend)
  );
  assign stall = if_valid && ((dec.use_rs && rs != REG_ZERO && rs_pend && !byp_a) ||
                              (dec.use_rt && rt != REG_ZERO && rt_pend && !byp_b) ||
                              (we && rd_pend));
  assign if_ready = !stall && (!ex_valid_q || ex_ready);
  assign accept = if_valid && if_ready;
  // register 0 reads as zero no matter what rf_32 returns
  assign op_a = rs == REG_ZERO ? '0 : byp_a ? wb_data : rf_out_a;
  assign op_b = rt == REG_ZERO ? '0 : byp_b ? wb_data : rf_out_b;
  always_comb begin
    ex_d = ex_q;
    ex_valid_d = accept ? 1'b1 : ex_ready ? 1'b0 : ex_valid_q;
    if (accept) begin
      ex_d.opcode = if_instr[31:26];
      ex_d.funct = if_instr[5:0];
      ex_d.shamt = if_instr[10:6];
      ex_d.rs_data = op_a;
      ex_d.rt_data = op_b;
      ex_d.imm = imm;
      ex_d.jtarget = if_instr[25:0];
      ex_d.dest = dest;
      ex_d.we = we;
      ex_d.illegal = dec.illegal;
      ex_d.pc = if_pc;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q <= ex_d;
    end
  assign ex_valid = ex_valid_q;
  assign ex_opcode = ex_q.opcode;
  assign ex_funct = ex_q.funct;
  assign ex_shamt = ex_q.shamt;
  assign ex_rs_data = ex_q.rs_data;
  assign ex_rt_data = ex_q.rt_data;
  assign ex_imm = ex_q.imm;
  assign ex_jtarget = ex_q.jtarget;
  assign ex_dest = ex_q.dest;
  assign ex_we = ex_q.we;
  assign ex_illegal = ex_q.illegal;
  assign ex_pc = ex_q.pc;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of decode, hazard stalls, backpressure and async reset for id_stage.
module tb_id_stage;
  logic clk, rst, if_valid, if_ready, wb_valid, ex_valid, ex_ready, ex_we, ex_illegal;
  logic [31:0] if_instr, if_pc, rf_out_a, rf_out_b, wb_data, ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic [4:0] rf_rs, rf_rt, wb_rd, ex_shamt, ex_dest;
  logic [5:0] ex_opcode, ex_funct;
  logic [25:0] ex_jtarget;
  logic [31:0] rf [32];
  int checks = 0;
  int failures = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_out_a(rf_out_a), .rf_out_b(rf_out_b),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_shamt(ex_shamt), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_jtarget(ex_jtarget), .ex_dest(ex_dest), .ex_we(ex_we), .ex_illegal(ex_illegal), .ex_pc(ex_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rf_32 stand-in: combinational reads, write at the clock edge
  assign rf_out_a = rf[rf_rs];
  assign rf_out_b = rf[rf_rt];
  always @(posedge clk) if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    rf[0] = 32'hDEADBEEF;
    for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
    tick; tick;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_ex_dest", 32'(ex_dest), 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_if_ready", 32'(if_ready), 1);
    rst = 1'b0;
    // addi $5,$0,-3
    if_valid = 1'b1; if_instr = 32'h2005FFFD; if_pc = 32'h100;
    #1;
    chk("addi_rf_rs", 32'(rf_rs), 0);
    chk("addi_rf_rt", 32'(rf_rt), 5);
    chk("addi_if_ready", 32'(if_ready), 1);
    tick;
    chk("addi_ex_valid", 32'(ex_valid), 1);
    chk("addi_imm", ex_imm, 32'hFFFFFFFD);
    chk("addi_dest", 32'(ex_dest), 5);
    chk("addi_we", 32'(ex_we), 1);
    chk("addi_rs_zero", ex_rs_data, 0);
    chk("addi_pc", ex_pc, 32'h100);
    chk("addi_opcode", 32'(ex_opcode), 32'h08);
    // ori $6,$0,0x8000 while $5 writes back
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hFFFFFFFD;
    if_instr = 32'h34068000; if_pc = 32'h104;
    tick;
    chk("ori_imm_zext", ex_imm, 32'h00008000);
    chk("ori_dest", 32'(ex_dest), 6);
    chk("ori_we", 32'(ex_we), 1);
    // illegal opcode 0x3F
    wb_rd = 5'd6; wb_data = 32'h00008000;
    if_instr = 32'hFC000000; if_pc = 32'h108;
    tick;
    chk("ill_flag", 32'(ex_illegal), 1);
    chk("ill_we", 32'(ex_we), 0);
    // add $3,$1,$2
    wb_valid = 1'b0;
    if_instr = 32'h00221820; if_pc = 32'h10C;
    tick;
    chk("add_dest", 32'(ex_dest), 3);
    chk("add_rs_data", ex_rs_data, 32'h10000001);
    chk("add_rt_data", ex_rt_data, 32'h10000002);
    chk("add_funct", 32'(ex_funct), 32'h20);
    chk("add_illegal", 32'(ex_illegal), 0);
    // sub $4,$3,$1 -> RAW on $3
    if_instr = 32'h00612022; if_pc = 32'h110;
    #1;
    chk("raw_stall", 32'(if_ready), 0);
    tick;
    chk("raw_drain_valid", 32'(ex_valid), 0);
    chk("raw_stall2", 32'(if_ready), 0);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h22222222;
    #1;
`ifdef ID_WB_BYPASS_EN
    chk("byp_if_ready", 32'(if_ready), 1);
    tick;
    wb_valid = 1'b0;
`else
    chk("nobyp_if_ready", 32'(if_ready), 0);
    tick;
    wb_valid = 1'b0;
    chk("nobyp_bubble", 32'(ex_valid), 0);
    #1;
    chk("nobyp_if_ready2", 32'(if_ready), 1);
    tick;
`endif
    chk("sub_valid", 32'(ex_valid), 1);
    chk("sub_rs_data", ex_rs_data, 32'h22222222);
    chk("sub_rt_data", ex_rt_data, 32'h10000001);
    chk("sub_dest", 32'(ex_dest), 4);
    // backpressure for 3 cycles with lw $7,0($0) waiting
    ex_ready = 1'b0;
    if_instr = 32'h8C070000; if_pc = 32'h114;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44444444;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_if_ready", 32'(if_ready), 0);
      tick;
      wb_valid = 1'b0;
      chk("bp_valid", 32'(ex_valid), 1);
      chk("bp_dest", 32'(ex_dest), 4);
      chk("bp_rs_data", ex_rs_data, 32'h22222222);
      chk("bp_pc", ex_pc, 32'h110);
    end
    // release with same-cycle writeback of $7: set wins
    ex_ready = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77777777;
    #1;
    chk("bp_release_ready", 32'(if_ready), 1);
    tick;
    wb_valid = 1'b0;
    chk("lw_opcode", 32'(ex_opcode), 32'h23);
    chk("lw_dest", 32'(ex_dest), 7);
    chk("lw_we", 32'(ex_we), 1);
    chk("lw_pc", ex_pc, 32'h114);
    // addi $7,$0,1 -> WAW on $7
    if_instr = 32'h20070001; if_pc = 32'h118;
    #1;
    chk("waw_stall", 32'(if_ready), 0);
    ex_ready = 1'b0;
    tick;
    chk("waw_hold_valid", 32'(ex_valid), 1);
    chk("waw_hold_dest", 32'(ex_dest), 7);
    // asynchronous reset mid-stall
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ex_valid), 0);
    chk("arst_dest", 32'(ex_dest), 0);
    chk("arst_we", 32'(ex_we), 0);
    rst = 1'b0; ex_ready = 1'b1;
    #1;
    chk("arst_sb_clear", 32'(if_ready), 1);
    tick;
    chk("post_rst_valid", 32'(ex_valid), 1);
    chk("post_rst_dest", 32'(ex_dest), 7);
    chk("post_rst_imm", ex_imm, 32'h1);
    chk("post_rst_pc", ex_pc, 32'h118);
    if_valid = 1'b0;
    tick;
    chk("idle_drain", 32'(ex_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
